// File: rtl/servo_pwm_array_if.sv
// Servo array command/status bundle.
// master drives enable/instr; slave returns pwm, frame_tick, at_target.
interface servo_pwm_array_if #(
  parameter int NUM_CH = 2
);
  logic                  enable;
  logic [2*NUM_CH-1:0]   instr;
  logic [NUM_CH-1:0]     pwm;
  logic                  frame_tick;
  logic [NUM_CH-1:0]     at_target;

  modport master (
    output enable, instr,
    input  pwm, frame_tick, at_target
  );

  modport slave (
    input  enable, instr,
    output pwm, frame_tick, at_target
  );
endinterface

// File: rtl/servo_pwm_array.sv
// Multi-channel continuous-rotation servo PWM with optional per-frame slew.
// Ports: clk, reset_n (async low), bus (slave: enable, instr, pwm, frame_tick, at_target).
module servo_pwm_array #(
  parameter int NUM_CH    = 2,
  parameter int CNT_W     = 12,
  parameter int PERIOD    = 3072,
  parameter int PW_BACK   = 154,
  parameter int PW_STOP   = 230,
  parameter int PW_FWD    = 307,
  parameter int RAMP_STEP = 0
) (
  input logic              clk,
  input logic              reset_n,
  servo_pwm_array_if.slave bus
);

  if (PW_FWD >= PERIOD || PW_BACK >= PERIOD || PW_STOP >= PERIOD) begin : g_bad_pw
    $error("pulse widths must be below PERIOD");
  end
  if (PERIOD > 2**CNT_W) begin : g_bad_period
    $error("PERIOD does not fit in CNT_W");
  end
  if (NUM_CH < 1) begin : g_bad_ch
    $error("NUM_CH must be at least 1");
  end

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t decode(input logic [1:0] c);
    unique case (1'b1)
      c == 2'b10: decode = cnt_t'(PW_BACK);
      c == 2'b01: decode = cnt_t'(PW_FWD);
      default:    decode = cnt_t'(PW_STOP);
    endcase
  endfunction

  // Step toward t by at most RAMP_STEP; never passes t.
  function automatic cnt_t slew(input cnt_t w, input cnt_t t);
    cnt_t step;
    step = cnt_t'(RAMP_STEP);
    if (RAMP_STEP == 0)
      slew = t;
    else if (t > w)
      slew = (t - w > step) ? w + step : t;
    else if (t < w)
      slew = (w - t > step) ? w - step : t;
    else
      slew = w;
  endfunction

  cnt_t                         count;
  logic [NUM_CH-1:0][CNT_W-1:0] width_q;
  logic [NUM_CH-1:0][CNT_W-1:0] width_d;
  logic [NUM_CH-1:0][CNT_W-1:0] tgt_d;
  logic [NUM_CH-1:0]            pwm_q;
  logic [NUM_CH-1:0]            at_q;
  logic                         wrap;

  assign wrap = bus.enable && (count == cnt_t'(PERIOD - 1));

  always_comb begin
    tgt_d   = '0;
    width_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      tgt_d[i]   = decode(bus.instr[2*i +: 2]);
      width_d[i] = slew(width_q[i], tgt_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (!bus.enable || wrap)
      count <= '0;
    else
      count <= count + cnt_t'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++)
        width_q[i] <= cnt_t'(PW_STOP);
      at_q <= '1;
    end else if (wrap) begin
      width_q <= width_d;
      for (int i = 0; i < NUM_CH; i++)
        at_q[i] <= (width_d[i] == tgt_d[i]);
    end
  end

  // At the wrap edge count is PERIOD-1, above every width, so the
  // width update never shapes the pulse being compared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++)
        pwm_q[i] <= bus.enable && (count < width_q[i]);
    end
  end

  assign bus.pwm        = pwm_q;
  assign bus.at_target  = at_q;
  assign bus.frame_tick = reset_n && bus.enable && (count == '0);

endmodule
